// File: rtl/dct_pkg.sv
// Shared constants and vector types for the 2-D DCT datapath.
// Imported by the transpose buffer and the 1-D DCT wrappers.
package dct_pkg;

    localparam int unsigned DCT_N  = 8;
    localparam int unsigned IDX_W  = $clog2(DCT_N);
    localparam int unsigned COEF_W = 32;

    typedef logic [COEF_W-1:0] coef_t;
    typedef coef_t [DCT_N-1:0] vec_t;

    function automatic logic is_last_idx(input logic [IDX_W-1:0] idx);
        return idx == IDX_W'(DCT_N - 1);
    endfunction

endpackage

// File: rtl/dct_tp_bank.sv
// One N x N register bank: whole-row write port, whole-column combinational read port.
// Contents are intentionally not reset.
module dct_tp_bank
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          we,
    input  logic [IDX_W-1:0]              wr_row,
    input  logic [DCT_N-1:0][DATA_W-1:0]  wr_vec,
    input  logic [IDX_W-1:0]              rd_col,
    output logic [DCT_N-1:0][DATA_W-1:0]  rd_vec
);

    logic [DATA_W-1:0] mem [DCT_N][DCT_N];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < DCT_N; k++) begin
                mem[wr_row][k] <= wr_vec[k];
            end
        end
    end

    always_comb begin
        rd_vec = '0;
        for (int r = 0; r < DCT_N; r++) begin
            rd_vec[r] = mem[r][rd_col];
        end
    end

endmodule

// File: rtl/dct_transpose_8x8.sv
// Ping-pong 8x8 transpose buffer between the row and column DCT passes.
// Rows are written into one bank while columns are read out of the other.
module dct_transpose_8x8
    import dct_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DCT_N-1:0][DATA_W-1:0]  in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DCT_N-1:0][DATA_W-1:0]  out_data,
    output logic                          out_last
);

    logic [1:0]       full_q, full_d;
    logic             wr_sel_q, wr_sel_d;
    logic             rd_sel_q, rd_sel_d;
    logic [IDX_W-1:0] wr_row_q, wr_row_d;
    logic [IDX_W-1:0] rd_col_q, rd_col_d;

    logic in_fire, out_fire;
    logic [1:0] bank_we;
    logic [DCT_N-1:0][DATA_W-1:0] rd_vec [2];

    // Handshake flags come from registered state only: no out_ready -> in_ready path.
    always_comb begin
        in_ready  = !full_q[wr_sel_q];
        out_valid = full_q[rd_sel_q];
        out_last  = out_valid && is_last_idx(rd_col_q);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
        bank_we   = '0;
        bank_we[wr_sel_q] = in_fire;
        out_data  = rd_vec[rd_sel_q];
    end

    // Writer and reader always target different banks, so both flag updates may coexist.
    always_comb begin
        full_d   = full_q;
        wr_sel_d = wr_sel_q;
        rd_sel_d = rd_sel_q;
        wr_row_d = wr_row_q;
        rd_col_d = rd_col_q;
        if (in_fire) begin
            wr_row_d = wr_row_q + IDX_W'(1);
            if (is_last_idx(wr_row_q)) begin
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = !wr_sel_q;
            end
        end
        if (out_fire) begin
            rd_col_d = rd_col_q + IDX_W'(1);
            if (is_last_idx(rd_col_q)) begin
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = !rd_sel_q;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_row_q <= '0;
            rd_col_q <= '0;
        end else begin
            full_q   <= full_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_row_q <= wr_row_d;
            rd_col_q <= rd_col_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        dct_tp_bank #(
            .DATA_W (DATA_W)
        ) u_bank (
            .clk    (clk),
            .we     (bank_we[b]),
            .wr_row (wr_row_q),
            .wr_vec (in_data),
            .rd_col (rd_col_q),
            .rd_vec (rd_vec[b])
        );
    end

endmodule

// File: tb/tb_dct_transpose_8x8.sv
// Self-checking bench for dct_transpose_8x8 against a block-queue reference model.
module tb_dct_transpose_8x8;

    localparam int N = 8;
    localparam int W = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [N-1:0][W-1:0]  in_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [N-1:0][W-1:0]  out_data;
    logic                 out_last;

    dct_transpose_8x8 #(
        .DATA_W (W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = !clk;

    int errors = 0;
    int checks = 0;

    // Reference model: completed blocks as row-major element queue, 64 entries per block.
    logic [W-1:0] blk_q [$];
    logic [W-1:0] cur [N*N];
    int m_row = 0;
    int m_col = 0;

    // DUT-observed handshake counters and last sampled in_ready.
    int dut_in_acc = 0;
    int dut_out_acc = 0;
    int ready_drops = 0;
    logic last_ir;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*W-1:0] pattern_row(input int r);
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(16 * r + k);
        return v;
    endfunction

    function automatic logic [N*W-1:0] random_row();
        logic [N*W-1:0] v;
        for (int k = 0; k < N; k++) v[k*W +: W] = $urandom;
        return v;
    endfunction

    task automatic model_reset();
        blk_q.delete();
        m_row = 0;
        m_col = 0;
    endtask

    // One clock: drive at negedge, compare against model, advance model at posedge.
    task automatic cycle(input logic vld, input logic [N*W-1:0] row, input logic ordy);
        int pend;
        logic exp_ir, exp_ov;
        @(negedge clk);
        in_valid  = vld;
        in_data   = row;
        out_ready = ordy;
        #1;
        pend   = blk_q.size() / (N * N);
        exp_ir = pend < 2;
        exp_ov = pend > 0;
        check("in_ready", W'(in_ready), W'(exp_ir));
        check("out_valid", W'(out_valid), W'(exp_ov));
        check("out_last", W'(out_last), W'(exp_ov && m_col == N - 1));
        if (exp_ov) begin
            for (int r = 0; r < N; r++) check("out_data", out_data[r], blk_q[r * N + m_col]);
        end
        last_ir = in_ready;
        if (in_valid && in_ready) dut_in_acc++;
        if (out_valid && out_ready) dut_out_acc++;
        @(posedge clk);
        if (vld && exp_ir) begin
            for (int k = 0; k < N; k++) cur[m_row * N + k] = row[k*W +: W];
            m_row++;
            if (m_row == N) begin
                for (int i = 0; i < N * N; i++) blk_q.push_back(cur[i]);
                m_row = 0;
            end
        end
        if (exp_ov && ordy) begin
            m_col++;
            if (m_col == N) begin
                for (int i = 0; i < N * N; i++) void'(blk_q.pop_front());
                m_col = 0;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_out_last", W'(out_last), '0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b1);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out_valid", W'(out_valid), '0);
        check("reset_out_last", W'(out_last), '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("reset_in_ready", W'(in_ready), 1);

        // Single block with known pattern.
        for (int r = 0; r < N; r++) cycle(1'b1, pattern_row(r), 1'b1);
        drain(10);

        // Four blocks back to back.
        dut_out_acc = 0;
        ready_drops = 0;
        for (int i = 0; i < 4 * N; i++) begin
            cycle(1'b1, random_row(), 1'b1);
            if (i >= N && !last_ir) ready_drops++;
        end
        drain(N + 2);
        check("stream_cols", W'(dut_out_acc), W'(4 * N));
        check("stream_ready_drops", W'(ready_drops), '0);

        // Output stalled while feeding: only two blocks fit.
        dut_in_acc = 0;
        for (int i = 0; i < 20; i++) cycle(1'b1, random_row(), 1'b0);
        check("stall_rows", W'(dut_in_acc), W'(2 * N));
        drain(2 * N + 2);

        // Writer waiting on full bank: one-cycle bubble after last column.
        for (int i = 0; i < 2 * N; i++) cycle(1'b1, random_row(), 1'b0);
        for (int i = 0; i < N; i++) cycle(1'b1, random_row(), 1'b1);
        check("bubble_T", W'(last_ir), '0);
        cycle(1'b1, random_row(), 1'b1);
        check("bubble_T1", W'(last_ir), 1);
        drain(3 * N);

        // Random valid/ready toggling over 100 blocks.
        dut_in_acc = 0;
        dut_out_acc = 0;
        begin
            int guard = 0;
            while (dut_in_acc < 100 * N && guard < 20000) begin
                cycle(1'($urandom_range(0, 1)), random_row(), 1'($urandom_range(0, 1)));
                guard++;
            end
            check("random_rows_done", W'(dut_in_acc), W'(100 * N));
        end
        drain(3 * N);
        check("random_cols", W'(dut_out_acc), W'(100 * N));

        // Reset after three rows discards the partial block.
        for (int r = 0; r < 3; r++) cycle(1'b1, random_row(), 1'b1);
        apply_reset();
        for (int r = 0; r < N; r++) cycle(1'b1, pattern_row(r + 1), 1'b1);
        drain(N + 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
